cve2_mem_arbiter: RTL and testbench

- Shares a single OBI-style memory port between the core's instruction-fetch and data (LSU) interfaces.
- Arbitrates requests, holds each selection stable until it is granted, and tracks outstanding transactions in order.
- Routes each response back to the requester that issued it.
- Sits between the core and a unified single-port memory/bus; runs on the gated core clock.

---
 rtl/cve2_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_cve2_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_mem_arbiter.sv
// rtl/cve2_mem_arbiter.sv - shares one OBI memory port between instruction fetch and LSU
// Define CVE2_ARB_RR_EN for round-robin arbitration; default is fixed data-over-instr priority.
module cve2_mem_arbiter #(
   parameter  int MaxOutstanding = 2,
   localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            instr_req_i,
   input  logic [31:0]     instr_addr_i,
   output logic            instr_gnt_o,
   output logic            instr_rvalid_o,
   output logic [31:0]     instr_rdata_o,
   output logic            instr_err_o,
   input  logic            data_req_i,
   input  logic            data_we_i,
   input  logic [3:0]      data_be_i,
   input  logic [31:0]     data_addr_i,
   input  logic [31:0]     data_wdata_i,
   output logic            data_gnt_o,
   output logic            data_rvalid_o,
   output logic [31:0]     data_rdata_o,
   output logic            data_err_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [3:0]      mem_be_o,
   output logic [31:0]     mem_addr_o,
   output logic [31:0]     mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [31:0]     mem_rdata_i,
   input  logic            mem_err_i,
   output logic [CntW-1:0] outstanding_o
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]                state_q, state_d;
   logic                      lock_src_q;
   logic [MaxOutstanding-1:0] src_q, src_d;
   logic [CntW-1:0]           cnt_q, cnt_d, wr_idx;
   logic                      full, sel, lock_hold, rr_pick, push, pop, head;

`ifdef CVE2_ARB_RR_EN
   // Source of the most recent grant; reset as instr so data wins the first tie.
   logic last_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b0;
      end else if (push) begin
         last_q <= sel;
      end
   end
   assign rr_pick = ~last_q;
`else
   assign rr_pick = 1'b1;
`endif

   assign full      = (cnt_q == CntW'(MaxOutstanding));
   assign lock_hold = (state_q == LOCKED) && (lock_src_q ? data_req_i : instr_req_i);

   // sel: 1 = data, 0 = instr
   always_comb begin
      sel = data_req_i;
      if (lock_hold) begin
         sel = lock_src_q;
      end else if (instr_req_i && data_req_i) begin
         sel = rr_pick;
      end
   end

   assign mem_req_o   = (instr_req_i | data_req_i) & ~full;
   assign mem_we_o    = sel ? data_we_i : 1'b0;
   assign mem_be_o    = sel ? data_be_i : 4'hF;
   assign mem_addr_o  = sel ? data_addr_i : instr_addr_i;
   assign mem_wdata_o = sel ? data_wdata_i : 32'h0;

   assign push        = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = push & ~sel;
   assign data_gnt_o  = push & sel;

   // Responses with nothing outstanding are dropped rather than routed.
   assign pop  = mem_rvalid_i & (cnt_q != '0);
   assign head = src_q[0];

   assign instr_rvalid_o = pop & ~head;
   assign instr_rdata_o  = (pop & ~head) ? mem_rdata_i : 32'h0;
   assign instr_err_o    = pop & ~head & mem_err_i;
   assign data_rvalid_o  = pop & head;
   assign data_rdata_o   = (pop & head) ? mem_rdata_i : 32'h0;
   assign data_err_o     = pop & head & mem_err_i;

   assign wr_idx = cnt_q - CntW'(pop);
   assign cnt_d  = cnt_q + CntW'(push) - CntW'(pop);

   always_comb begin
      src_d = pop ? (src_q >> 1) : src_q;
      for (int i = 0; i < MaxOutstanding; i++) begin
         if (push && (wr_idx == CntW'(i))) begin
            src_d[i] = sel;
         end
      end
   end

   // A dropped locked request simply falls through to re-arbitration here.
   always_comb begin
      state_d = (mem_req_o && !mem_gnt_i) ? LOCKED : IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         lock_src_q <= 1'b0;
         src_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         lock_src_q <= sel;
         src_q      <= src_d;
         cnt_q      <= cnt_d;
      end
   end

   assign outstanding_o = cnt_q;

   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!((state_q == LOCKED) && !lock_hold))
            else $warning("arbiter: locked requester withdrew its request");
         assert (!(mem_rvalid_i && (cnt_q == '0)))
            else $warning("arbiter: response with no outstanding transaction");
      end
   end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// tb/tb_cve2_mem_arbiter.sv - scoreboard bench for cve2_mem_arbiter
// Build with or without CVE2_ARB_RR_EN to match the design.
module tb_cve2_mem_arbiter;
   localparam int MaxOut = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [1:0]  outstanding_o;

   cve2_mem_arbiter #(.MaxOutstanding(MaxOut)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .outstanding_o(outstanding_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        src;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t resp_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      instr_req_i = 0; instr_addr_i = 0;
      data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic push_exp(input logic src, input logic [31:0] rd, input logic err);
      exp_t e;
      e.src = src; e.rdata = rd; e.err = err;
      sb.push_back(e);
   endtask

   task automatic drive_resp();
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
         resp_e.src = 0; resp_e.rdata = 0; resp_e.err = 0;
      end else begin
         resp_e = sb.pop_front();
      end
      mem_rvalid_i = 1; mem_rdata_i = resp_e.rdata; mem_err_i = resp_e.err;
   endtask

   task automatic check_resp();
      check("instr_rvalid", instr_rvalid_o, !resp_e.src);
      check("data_rvalid", data_rvalid_o, resp_e.src);
      check("instr_rdata", instr_rdata_o, resp_e.src ? 32'h0 : resp_e.rdata);
      check("data_rdata", data_rdata_o, resp_e.src ? resp_e.rdata : 32'h0);
      check("instr_err", instr_err_o, !resp_e.src && resp_e.err);
      check("data_err", data_err_o, resp_e.src && resp_e.err);
   endtask

   initial begin
      logic w;
      idle_inputs();
      rst_ni = 0;
      tick(); tick(); settle();
      check("rst_mem_req", mem_req_o, 0);
      check("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
      check("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
      check("rst_outstanding", outstanding_o, 0);
      rst_ni = 1;
      tick();

      // fetch only
      instr_req_i = 1; instr_addr_i = 32'h80; mem_gnt_i = 1; settle();
      check("fetch_req", mem_req_o, 1);
      check("fetch_be", mem_be_o, 4'hF);
      check("fetch_we", mem_we_o, 0);
      check("fetch_addr", mem_addr_o, 32'h80);
      check("fetch_wdata", mem_wdata_o, 0);
      check("fetch_gnt", {instr_gnt_o, data_gnt_o}, 2'b10);
      push_exp(0, 32'hDEADBEEF, 0);
      tick();
      idle_inputs(); drive_resp(); settle();
      check_resp();
      check("fetch_outst", outstanding_o, 1);
      tick(); idle_inputs(); settle();
      check("fetch_outst_end", outstanding_o, 0);

      // contention under fixed priority: data first
      instr_req_i = 1; instr_addr_i = 32'h200;
      data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h100; data_wdata_i = 32'h55;
      mem_gnt_i = 1; settle();
      check("cont_gnt1", {instr_gnt_o, data_gnt_o}, 2'b01);
      check("cont_addr1", mem_addr_o, 32'h100);
      check("cont_be1", mem_be_o, 4'h3);
      check("cont_we1", mem_we_o, 1);
      check("cont_wdata1", mem_wdata_o, 32'h55);
      push_exp(1, 32'h11111111, 0);
      tick();
      data_req_i = 0; settle();
      check("cont_gnt2", {instr_gnt_o, data_gnt_o}, 2'b10);
      check("cont_addr2", mem_addr_o, 32'h200);
      check("cont_outst1", outstanding_o, 1);
      push_exp(0, 32'h22222222, 0);
      tick();
      idle_inputs(); drive_resp(); settle();
      check("cont_outst2", outstanding_o, 2);
      check_resp();
      tick();
      idle_inputs(); drive_resp(); settle();
      check("cont_outst3", outstanding_o, 1);
      check_resp();
      tick(); idle_inputs(); settle();
      check("cont_outst4", outstanding_o, 0);

      // lock holds instr until granted
      instr_req_i = 1; instr_addr_i = 32'h300; settle();
      check("lock_addr1", mem_addr_o, 32'h300);
      check("lock_gnt1", {instr_gnt_o, data_gnt_o}, 0);
      tick();
      data_req_i = 1; data_addr_i = 32'h400; data_be_i = 4'hF; settle();
      check("lock_addr2", mem_addr_o, 32'h300);
      tick(); settle();
      check("lock_addr3", mem_addr_o, 32'h300);
      tick();
      mem_gnt_i = 1; settle();
      check("lock_gnt4", {instr_gnt_o, data_gnt_o}, 2'b10);
      check("lock_addr4", mem_addr_o, 32'h300);
      push_exp(0, 32'h33333333, 0);
      tick();
      instr_req_i = 0; settle();
      check("lock_gnt5", {instr_gnt_o, data_gnt_o}, 2'b01);
      check("lock_addr5", mem_addr_o, 32'h400);
      push_exp(1, 32'h44444444, 0);
      tick();
      idle_inputs(); drive_resp(); settle(); check_resp();
      tick();
      idle_inputs(); drive_resp(); settle(); check_resp();
      tick(); idle_inputs();

      // full: no grants, no bypass on same-cycle response
      instr_req_i = 1; instr_addr_i = 32'h40; mem_gnt_i = 1; settle();
      check("full_gnt1", instr_gnt_o, 1);
      push_exp(0, 32'hA0A0A0A0, 0);
      tick(); settle();
      check("full_gnt2", instr_gnt_o, 1);
      push_exp(0, 32'hB0B0B0B0, 0);
      tick(); settle();
      check("full_outst", outstanding_o, 2);
      check("full_req", mem_req_o, 0);
      check("full_gnt3", instr_gnt_o, 0);
      tick();
      drive_resp(); settle();
      check("full_req_rv", mem_req_o, 0);
      check("full_gnt_rv", instr_gnt_o, 0);
      check_resp();
      tick();
      mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0; settle();
      check("full_gnt_after", instr_gnt_o, 1);
      push_exp(0, 32'hC0C0C0C0, 0);
      tick();
      idle_inputs(); drive_resp(); settle(); check_resp();
      tick();
      idle_inputs(); drive_resp(); settle(); check_resp();
      tick(); idle_inputs();

      // error response and spurious rvalid
      data_req_i = 1; data_addr_i = 32'h500; data_be_i = 4'hF; mem_gnt_i = 1; settle();
      check("err_gnt", data_gnt_o, 1);
      push_exp(1, 32'h0000CAFE, 1);
      tick();
      idle_inputs(); drive_resp(); settle(); check_resp();
      tick();
      idle_inputs(); mem_rvalid_i = 1; mem_rdata_i = 32'hBAD; mem_err_i = 1; settle();
      check("spur_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
      check("spur_rdata", instr_rdata_o | data_rdata_o, 0);
      check("spur_err", {instr_err_o, data_err_o}, 0);
      tick(); idle_inputs(); settle();
      check("spur_outst", outstanding_o, 0);

      // reset with a transaction in flight
      data_req_i = 1; data_addr_i = 32'h600; mem_gnt_i = 1; settle();
      tick(); idle_inputs(); settle();
      check("mid_outst_pre", outstanding_o, 1);
      rst_ni = 0; settle();
      check("mid_rst_outst", outstanding_o, 0);
      tick(); rst_ni = 1; tick();

      // continuous contention, one response per cycle keeps one outstanding
      instr_req_i = 1; instr_addr_i = 32'h700;
      data_req_i = 1; data_addr_i = 32'h800; data_be_i = 4'hF; mem_gnt_i = 1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) drive_resp();
         settle();
`ifdef CVE2_ARB_RR_EN
         w = (k % 2 == 0);
`else
         w = 1'b1;
`endif
         check("arb_data_gnt", data_gnt_o, w);
         check("arb_instr_gnt", instr_gnt_o, !w);
         check("arb_addr", mem_addr_o, w ? 32'h800 : 32'h700);
         if (k > 0) begin
            check_resp();
            check("arb_outst", outstanding_o, 1);
         end
         push_exp(w, 32'h70000000 + k, 0);
         tick();
      end
      idle_inputs(); drive_resp(); settle(); check_resp();
      tick(); idle_inputs(); settle();
      check("end_outst", outstanding_o, 0);
      check("end_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
